axi4_write_responder: RTL

- AXI4 write-channel responder (slave side) for the AW/W/B interface that our write initiator drives.
- Accepts one INCR burst at a time, commits beats into an internal byte-laned memory and returns BRESP.
- Checks for 4KB-boundary and range errors.
- Exposes a combinational read-back port so benches can check memory contents directly.

---
 rtl/axi4_write_responder_pkg.sv | 19 +
 rtl/axi_wr_mem.sv | 28 ++
 rtl/axi4_write_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/axi4_write_responder_pkg.sv
// rtl/axi4_write_responder_pkg.sv - shared types and constants for the AXI4 write responder
package axi4_write_responder_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } state_t;

    localparam int BOUNDARY_4KB = 4096;

endpackage

// File: rtl/axi_wr_mem.sv
// rtl/axi_wr_mem.sv - byte-enable synchronous-write memory with combinational read-back
module axi_wr_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] idx,
    input  logic [DATA_WIDTH/8-1:0]      be,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Commit only the enabled byte lanes; contents survive reset on purpose
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (we && be[b]) begin
                mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/axi4_write_responder.sv
// rtl/axi4_write_responder.sv - AXI4 INCR write-channel responder with 4KB and range checking
module axi4_write_responder
    import axi4_write_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         ARESET,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic [7:0]                   AWLEN,
    input  logic [2:0]                   AWSIZE,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic                         WVALID,
    input  logic                         WLAST,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_data
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int EW        = ADDR_WIDTH + 1;
    localparam int PAGE_BITS = $clog2(BOUNDARY_4KB);
    localparam logic [EW-1:0] MEM_BYTES = EW'(MEM_DEPTH * BYTES);

    state_t                state;
    resp_t                 bresp_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [8:0]            beat_cnt;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  err_q, wlast_err_q;

    logic [EW-1:0]         aw_base, aw_span, aw_last;
    logic                  aw_err;
    logic [ADDR_WIDTH-1:0] size_step, addr_next;
    logic [BYTES-1:0]      be;
    logic [IDX_W-1:0]      word_idx;
    logic                  beat, last_beat, mem_we;
    int                    lane, cont, cont_base;

    // Burst legality, judged once at the address handshake with one spare bit so the end address cannot wrap
    always_comb begin
        aw_base = {1'b0, AWADDR};
        aw_span = EW'({1'b0, AWLEN} + 9'd1) << AWSIZE;
        aw_last = aw_base + aw_span - EW'(1);
        aw_err  = (int'(AWSIZE) > LANE_BITS)
               || (aw_last[EW-1:PAGE_BITS] != aw_base[EW-1:PAGE_BITS])
               || (aw_last >= MEM_BYTES);
    end

    // Lanes from the beat address up to the end of its 2^size container; later beats are container-aligned
    always_comb begin
        lane      = int'(addr_q) % BYTES;
        cont      = 1 << int'(size_q);
        cont_base = lane - (lane % cont);
        be        = '0;
        for (int l = 0; l < BYTES; l++) begin
            be[l] = (l >= lane) && (l < cont_base + cont);
        end
        size_step = ADDR_WIDTH'(1) << size_q;
        addr_next = (addr_q & ~(size_step - ADDR_WIDTH'(1))) + size_step;
        word_idx  = IDX_W'(addr_q >> LANE_BITS);
        beat      = (state == DATA) && WVALID && wready_q;
        last_beat = (beat_cnt == {1'b0, len_q});
        mem_we    = beat && !err_q;
    end

    // Handshake FSM: every handshake output is a register updated here
    always_ff @(posedge clk) begin
        if (ARESET) begin
            state       <= IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= OKAY;
            beat_cnt    <= '0;
            err_q       <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    awready_q <= 1'b1;
                    if (AWVALID && awready_q) begin
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        addr_q      <= AWADDR;
                        len_q       <= AWLEN;
                        size_q      <= AWSIZE;
                        err_q       <= aw_err;
                        wlast_err_q <= 1'b0;
                        beat_cnt    <= '0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        addr_q   <= addr_next;
                        if (last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (err_q || wlast_err_q || !WLAST) ? SLVERR : OKAY;
                            state    <= RESP;
                        end else if (WLAST) begin
                            wlast_err_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

    axi_wr_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk      (clk),
        .we       (mem_we),
        .idx      (word_idx),
        .be       (be),
        .wdata    (WDATA),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule
